riscy_bus_arbiter: RTL and testbench



---
 rtl/riscy_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_riscy_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscy_bus_arbiter.sv
// ============================================================================
// riscy_bus_arbiter: one-owner-at-a-time grant arbiter for the RISCY InOut bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscy_bus_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 16,
  parameter int PRIO0    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         oe,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int OW = $clog2(N);
  localparam int SW = OW + 1;
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic [N-1:0]    oe_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    mask_q;
  logic            terr_q;

  logic [N-1:0]    req_eff_d;
  logic [OW-1:0]   win_d;
  logic [SW-1:0]   scan_d;
  logic            own_req;
  logic            own_rel;
  logic            at_max;
  logic            forced;

  // A requester revoked by timeout sits out one arbitration unless nobody else wants the bus.
  always_comb begin
    req_eff_d = req & ~mask_q;
    if (req_eff_d == '0) begin
      req_eff_d = req;
    end
    win_d  = '0;
    scan_d = '0;
    for (int i = N; i >= 1; i--) begin
      scan_d = {1'b0, last_q} + SW'(i);
      if (scan_d >= SW'(N)) begin
        scan_d = scan_d - SW'(N);
      end
      if (req_eff_d[scan_d[OW-1:0]]) begin
        win_d = scan_d[OW-1:0];
      end
    end
    if ((PRIO0 != 0) && req_eff_d[0]) begin
      win_d = '0;
    end
  end

  assign own_req = req[owner_q];
  assign own_rel = rel[owner_q];
  assign at_max  = (cnt_q == CW'(MAX_HOLD));
  // Only a still-wanted, unreleased bus at the limit counts as a forced revoke.
  assign forced  = own_req && !own_rel;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      oe_q    <= '0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
      cnt_q   <= '0;
      mask_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        S_IDLE, S_TURN: begin
          mask_q <= '0;
          if (req_eff_d != '0) begin
            state_q <= S_HOLD;
            gnt_q   <= N'(1) << win_d;
            oe_q    <= N'(1) << win_d;
            owner_q <= win_d;
            last_q  <= win_d;
            cnt_q   <= CW'(1);
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            oe_q    <= '0;
            cnt_q   <= '0;
          end
        end
        S_HOLD: begin
          if (!own_req || own_rel || at_max) begin
            state_q <= S_TURN;
            gnt_q   <= '0;
            oe_q    <= '0;
            cnt_q   <= '0;
            terr_q  <= forced;
            mask_q  <= forced ? gnt_q : '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          oe_q    <= '0;
          cnt_q   <= '0;
          mask_q  <= '0;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign oe          = oe_q;
  assign owner       = owner_q;
  assign busy        = |gnt_q;
  assign timeout_err = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_riscy_bus_arbiter.sv
// ============================================================================
// tb_riscy_bus_arbiter: scoreboard bench, two arbiters (round-robin/MAX 4 and prio0/MAX 16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_riscy_bus_arbiter;

  logic       CLK;
  logic       RST;
  logic [2:0] req_a, rel_a, gnt_a, oe_a;
  logic [2:0] req_b, rel_b, gnt_b, oe_b;
  logic [1:0] own_a, own_b;
  logic       busy_a, busy_b, terr_a, terr_b;

  riscy_bus_arbiter #(.N(3), .MAX_HOLD(4), .PRIO0(0)) u_dut_a (
    .CLK(CLK), .RST(RST), .req(req_a), .rel(rel_a), .gnt(gnt_a), .oe(oe_a),
    .owner(own_a), .busy(busy_a), .timeout_err(terr_a)
  );

  riscy_bus_arbiter #(.N(3), .MAX_HOLD(16), .PRIO0(1)) u_dut_b (
    .CLK(CLK), .RST(RST), .req(req_b), .rel(rel_b), .gnt(gnt_b), .oe(oe_b),
    .owner(own_b), .busy(busy_b), .timeout_err(terr_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int         st;    // 0 idle, 1 hold, 2 turn
    int         last;
    int         cnt;
    int         own;
    logic [2:0] mask;
    logic [2:0] gnt;
    logic       terr;
  } model_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] oe;
    logic [1:0] own;
    logic       busy;
    logic       terr;
  } exp_t;

  exp_t   qa[$];
  exp_t   qb[$];
  model_t ma, mb;
  int     total = 0;
  int     bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic model_t mreset();
    model_t m;
    m.st = 0; m.last = 2; m.cnt = 0; m.own = 0;
    m.mask = 3'b000; m.gnt = 3'b000; m.terr = 1'b0;
    return m;
  endfunction

  function automatic bit bitof(input logic [2:0] v, input int i);
    return ((v >> i) & 3'b001) != 3'b000;
  endfunction

  function automatic int pick(input model_t m, input logic [2:0] rq, input bit prio);
    logic [2:0] eff;
    int j;
    eff = rq & ~m.mask;
    if (eff == 3'b000) eff = rq;
    if (prio && bitof(eff, 0)) return 0;
    for (int i = 1; i <= 3; i++) begin
      j = (m.last + i) % 3;
      if (bitof(eff, j)) return j;
    end
    return -1;
  endfunction

  function automatic model_t mstep(input model_t m, input int maxh, input bit prio,
                                   input logic [2:0] rq, input logic [2:0] rl);
    model_t n;
    int     w;
    bit     oreq, orel, frc;
    n = m;
    n.terr = 1'b0;
    if (m.st == 1) begin
      oreq = bitof(rq, m.own);
      orel = bitof(rl, m.own);
      if (!oreq || orel || m.cnt == maxh) begin
        frc    = oreq && !orel;
        n.st   = 2;
        n.gnt  = 3'b000;
        n.cnt  = 0;
        n.terr = frc;
        n.mask = frc ? m.gnt : 3'b000;
      end else begin
        n.cnt = m.cnt + 1;
      end
    end else begin
      w = pick(m, rq, prio);
      n.mask = 3'b000;
      if (w >= 0) begin
        n.st = 1; n.gnt = 3'b001 << w; n.own = w; n.last = w; n.cnt = 1;
      end else begin
        n.st = 0; n.gnt = 3'b000; n.cnt = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t mexp(input model_t m);
    exp_t e;
    e.gnt = m.gnt; e.oe = m.gnt; e.own = 2'(m.own); e.busy = |m.gnt; e.terr = m.terr;
    return e;
  endfunction

  task automatic cyc(input logic [2:0] ra, input logic [2:0] la,
                     input logic [2:0] rb, input logic [2:0] lb);
    exp_t got;
    req_a = ra; rel_a = la; req_b = rb; rel_b = lb;
    ma = mstep(ma, 4, 1'b0, ra, la);
    qa.push_back(mexp(ma));
    mb = mstep(mb, 16, 1'b1, rb, lb);
    qb.push_back(mexp(mb));
    @(posedge CLK);
    #1;
    got = {gnt_a, oe_a, own_a, busy_a, terr_a};
    check("a_outputs", 32'(got), 32'(qa.pop_front()));
    got = {gnt_b, oe_b, own_b, busy_b, terr_b};
    check("b_outputs", 32'(got), 32'(qb.pop_front()));
    check("a_oe_onehot0", 32'($onehot0(oe_a)), 32'd1);
    check("b_oe_onehot0", 32'($onehot0(oe_b)), 32'd1);
  endtask

  int n_on;
  int order[4] = '{0, 1, 2, 0};

  initial begin
    RST = 1'b0;
    req_a = '0; rel_a = '0; req_b = '0; rel_b = '0;
    ma = mreset();
    mb = mreset();
    #12;
    check("rst_a", 32'({gnt_a, oe_a, own_a, busy_a, terr_a}), 32'(mexp(ma)));
    check("rst_b", 32'({gnt_b, oe_b, own_b, busy_b, terr_b}), 32'(mexp(mb)));
    RST = 1'b1;

    // Single requester on b: 4 granted cycles, then TURN, then IDLE.
    n_on = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(3'b000, 3'b000, 3'b001, 3'b000);
      if (gnt_b == 3'b001) n_on++;
    end
    check("t1_gnt_cycles", 32'(n_on), 32'd4);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);
    check("t1_turn_gnt", 32'(gnt_b), 32'h0);
    check("t1_turn_busy", 32'(busy_b), 32'h0);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);

    // Round robin on a: all requesting, each owner releases after two cycles.
    for (int k = 0; k < 4; k++) begin
      cyc(3'b111, 3'b000, 3'b000, 3'b000);
      check("t2_order", 32'(gnt_a), 32'(3'b001 << order[k]));
      cyc(3'b111, 3'b000, 3'b000, 3'b000);
      cyc(3'b111, 3'b001 << order[k], 3'b000, 3'b000);
      check("t2_gap", 32'(gnt_a), 32'h0);
    end
    cyc(3'b000, 3'b000, 3'b000, 3'b000);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);

    // Priority 0 on b: no preemption, non-owner rel ignored, 0 wins after TURN.
    cyc(3'b000, 3'b000, 3'b110, 3'b000);
    check("t3_first", 32'(gnt_b), 32'h2);
    cyc(3'b000, 3'b000, 3'b110, 3'b000);
    cyc(3'b000, 3'b000, 3'b111, 3'b100);
    cyc(3'b000, 3'b000, 3'b111, 3'b000);
    check("t3_no_preempt", 32'(gnt_b), 32'h2);
    cyc(3'b000, 3'b000, 3'b111, 3'b010);
    check("t3_turn", 32'(gnt_b), 32'h0);
    cyc(3'b000, 3'b000, 3'b111, 3'b000);
    check("t3_prio0", 32'(gnt_b), 32'h1);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);

    // Timeout on a: sole hog regranted, then masked when 0 also wants the bus.
    n_on = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(3'b100, 3'b000, 3'b000, 3'b000);
      if (gnt_a == 3'b100) n_on++;
    end
    check("t4_hold_cycles", 32'(n_on), 32'd4);
    check("t4_terr", 32'(terr_a), 32'h1);
    cyc(3'b100, 3'b000, 3'b000, 3'b000);
    check("t4_regrant", 32'(gnt_a), 32'h4);
    check("t4_terr_pulse", 32'(terr_a), 32'h0);
    for (int i = 0; i < 4; i++) cyc(3'b101, 3'b000, 3'b000, 3'b000);
    check("t5_terr", 32'(terr_a), 32'h1);
    cyc(3'b101, 3'b000, 3'b000, 3'b000);
    check("t5_next_gnt", 32'(gnt_a), 32'h1);
    check("t5_owner", 32'(own_a), 32'h0);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);

    // rel coinciding with the hold limit is a plain release.
    for (int i = 0; i < 4; i++) cyc(3'b010, 3'b000, 3'b000, 3'b000);
    cyc(3'b010, 3'b010, 3'b000, 3'b000);
    check("rel_at_max_terr", 32'(terr_a), 32'h0);
    check("rel_at_max_gnt", 32'(gnt_a), 32'h0);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);

    // Asynchronous reset between edges while b holds the bus.
    cyc(3'b000, 3'b000, 3'b100, 3'b000);
    cyc(3'b000, 3'b000, 3'b100, 3'b000);
    #3;
    RST = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt_b), 32'h0);
    check("arst_oe", 32'(oe_b), 32'h0);
    check("arst_busy", 32'(busy_b), 32'h0);
    ma = mreset();
    mb = mreset();
    check("arst_a", 32'({gnt_a, oe_a, own_a, busy_a, terr_a}), 32'(mexp(ma)));
    #1;
    RST = 1'b1;
    cyc(3'b000, 3'b000, 3'b010, 3'b000);
    check("arst_first_gnt", 32'(gnt_b), 32'h2);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);
    cyc(3'b000, 3'b000, 3'b000, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
